// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and helpers for the local-DMEM arbiter slice.
//                dmem_owner_e tags which requester owns the read data that
//                returns one cycle after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        DMEM_OWNER_NONE = 2'd0,
        DMEM_OWNER_CORE = 2'd1,
        DMEM_OWNER_NET  = 2'd2
    } dmem_owner_e;

    // Returns at least 1 so a depth of 1 still yields a legal 1-bit address.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_counter
//  Description : Clear/up counter that saturates at MAX_VAL. Clear has
//                priority over up.
//  Ports       : clk_i, reset_i (async, active-low), clear_i, up_i,
//                count_o (current count)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_VAL = 4,
    parameter int WIDTH   = safe_clog2(MAX_VAL + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (up_i && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-ported local DMEM between the core
//                load/store path and incoming network requests. One grant
//                per cycle, core preferred unless the network has been
//                denied MAX_STARVE cycles in a row. Read data (1-cycle
//                latency) is steered back to the requester that issued it.
//                Also holds the LR/SC load-reservation register.
//  Ports       : clk_i, reset_i (async, active-low)
//                core_* : core request / accept / read return
//                net_*  : network request / accept / read return
//                mem_*  : SRAM request and read data
//                clear_reserve_i, reserved_o, reserved_addr_o,
//                break_reserve_o : reservation control and status
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DMEM_SIZE  = 1024,
    parameter  int MAX_STARVE = 4,
    localparam int ADDR_WIDTH = safe_clog2(DMEM_SIZE),
    localparam int MASK_WIDTH = DATA_WIDTH >> 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  core_v_i,
    input  logic                  core_w_i,
    input  logic                  core_reserve_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_data_i,
    input  logic [MASK_WIDTH-1:0] core_mask_i,
    output logic                  core_yumi_o,
    output logic                  core_rdata_v_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,

    input  logic                  net_v_i,
    input  logic                  net_w_i,
    input  logic [ADDR_WIDTH-1:0] net_addr_i,
    input  logic [DATA_WIDTH-1:0] net_data_i,
    input  logic [MASK_WIDTH-1:0] net_mask_i,
    output logic                  net_yumi_o,
    output logic                  net_rdata_v_o,
    output logic [DATA_WIDTH-1:0] net_rdata_o,

    output logic                  mem_v_o,
    output logic                  mem_w_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [MASK_WIDTH-1:0] mem_mask_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,

    input  logic                  clear_reserve_i,
    output logic                  reserved_o,
    output logic [ADDR_WIDTH-1:0] reserved_addr_o,
    output logic                  break_reserve_o
);

    localparam int               C_CNT_W      = safe_clog2(MAX_STARVE + 1);
    localparam logic [C_CNT_W-1:0] C_MAX_STARVE = C_CNT_W'(MAX_STARVE);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [C_CNT_W-1:0] w_starve_cnt;
    logic               w_starved;
    logic               w_core_gnt;
    logic               w_net_gnt;

    assign w_starved  = (w_starve_cnt == C_MAX_STARVE);
    assign w_core_gnt = core_v_i & (~net_v_i | ~w_starved);
    assign w_net_gnt  = net_v_i  & (~core_v_i | w_starved);

    assign core_yumi_o = w_core_gnt;
    assign net_yumi_o  = w_net_gnt;

    // Counts consecutive cycles the network waited; restarts whenever it
    // either wins or withdraws.
    dmem_arbiter_counter #(
        .MAX_VAL (MAX_STARVE),
        .WIDTH   (C_CNT_W)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (~net_v_i | w_net_gnt),
        .up_i    (net_v_i & ~w_net_gnt),
        .count_o (w_starve_cnt)
    );

    // ------------------------------------------------------------------
    // SRAM request mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_mask_o = '0;
        if (w_core_gnt) begin
            mem_w_o    = core_w_i;
            mem_addr_o = core_addr_i;
            mem_data_o = core_data_i;
            mem_mask_o = core_mask_i;
        end else if (w_net_gnt) begin
            mem_w_o    = net_w_i;
            mem_addr_o = net_addr_i;
            mem_data_o = net_data_i;
            mem_mask_o = net_mask_i;
        end
    end

    assign mem_v_o = w_core_gnt | w_net_gnt;

    // ------------------------------------------------------------------
    // Read-return owner
    // ------------------------------------------------------------------
    dmem_owner_e r_rd_owner;
    dmem_owner_e w_rd_owner_nxt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_owner <= DMEM_OWNER_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_owner_nxt = DMEM_OWNER_NONE;
        if (w_core_gnt && !core_w_i) begin
            w_rd_owner_nxt = DMEM_OWNER_CORE;
        end else if (w_net_gnt && !net_w_i) begin
            w_rd_owner_nxt = DMEM_OWNER_NET;
        end
    end

    assign core_rdata_v_o = (r_rd_owner == DMEM_OWNER_CORE);
    assign net_rdata_v_o  = (r_rd_owner == DMEM_OWNER_NET);
    assign core_rdata_o   = mem_data_i;
    assign net_rdata_o    = mem_data_i;

    // ------------------------------------------------------------------
    // Load reservation
    // ------------------------------------------------------------------
    logic                  r_reserved;
    logic [ADDR_WIDTH-1:0] r_reserved_addr;
    logic                  r_break;
    logic                  w_lr_set;
    logic                  w_hit;

    // Reserve on a write request is ignored: an LR is only a read.
    assign w_lr_set = w_core_gnt & ~core_w_i & core_reserve_i;
    // A zero-mask write changes no bytes, so it must not kill the reservation.
    assign w_hit    = r_reserved & mem_v_o & mem_w_o
                    & (mem_addr_o == r_reserved_addr) & (|mem_mask_o);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_reserved      <= 1'b0;
            r_reserved_addr <= '0;
            r_break         <= 1'b0;
        end else begin
            r_break <= w_hit;
            // A new LR overrides a same-cycle clear request.
            if (w_lr_set) begin
                r_reserved      <= 1'b1;
                r_reserved_addr <= core_addr_i;
            end else if (w_hit || clear_reserve_i) begin
                r_reserved      <= 1'b0;
            end
        end
    end

    assign reserved_o      = r_reserved;
    assign reserved_addr_o = r_reserved_addr;
    assign break_reserve_o = r_break;

    a_no_reserve_on_write : assert property (
        @(posedge clk_i) disable iff (!reset_i)
        !(core_v_i && core_w_i && core_reserve_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed, self-checking bench for dmem_arbiter. Read
//                returns are checked by a monitor against expected data
//                queued when each read is granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int DS = 1024;
    localparam int AW = 10;
    localparam int MW = 4;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_v, core_w, core_reserve;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic [MW-1:0] core_mask;
    logic          core_yumi, core_rdata_v;
    logic [DW-1:0] core_rdata;
    logic          net_v, net_w;
    logic [AW-1:0] net_addr;
    logic [DW-1:0] net_data;
    logic [MW-1:0] net_mask;
    logic          net_yumi, net_rdata_v;
    logic [DW-1:0] net_rdata;
    logic          mem_v, mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_mask;
    logic [DW-1:0] mem_rdata;
    logic          clear_reserve;
    logic          reserved;
    logic [AW-1:0] reserved_addr;
    logic          break_reserve;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] core_q[$];
    logic [DW-1:0] net_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH (DW),
        .DMEM_SIZE  (DS),
        .MAX_STARVE (MS)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_n),
        .core_v_i        (core_v),
        .core_w_i        (core_w),
        .core_reserve_i  (core_reserve),
        .core_addr_i     (core_addr),
        .core_data_i     (core_data),
        .core_mask_i     (core_mask),
        .core_yumi_o     (core_yumi),
        .core_rdata_v_o  (core_rdata_v),
        .core_rdata_o    (core_rdata),
        .net_v_i         (net_v),
        .net_w_i         (net_w),
        .net_addr_i      (net_addr),
        .net_data_i      (net_data),
        .net_mask_i      (net_mask),
        .net_yumi_o      (net_yumi),
        .net_rdata_v_o   (net_rdata_v),
        .net_rdata_o     (net_rdata),
        .mem_v_o         (mem_v),
        .mem_w_o         (mem_w),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_wdata),
        .mem_mask_o      (mem_mask),
        .mem_data_i      (mem_rdata),
        .clear_reserve_i (clear_reserve),
        .reserved_o      (reserved),
        .reserved_addr_o (reserved_addr),
        .break_reserve_o (break_reserve)
    );

    // SRAM model: byte-masked, 1-cycle read latency. Preloaded on the first
    // edge (reset is held then) with {4{addr[7:0]}}, and 0xDEADBEEF at 0x10.
    logic [DW-1:0] sram [DS];
    logic          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DS; i++) begin
                logic [7:0] b8;
                b8 = 8'(i);
                sram[i] <= {4{b8}};
            end
            sram[16] <= 32'hDEAD_BEEF;
            loaded   <= 1'b1;
        end else if (mem_v) begin
            if (mem_w) begin
                for (int b = 0; b < MW; b++)
                    if (mem_mask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read return must match the oldest expected entry.
    always @(negedge clk) begin
        if (core_rdata_v) begin
            if (core_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL core_rdata_unexpected: got 0x%08h expected no return at %0t", core_rdata, $time);
            end else begin
                check("core_rdata", core_rdata, core_q.pop_front());
            end
        end
        if (net_rdata_v) begin
            if (net_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL net_rdata_unexpected: got 0x%08h expected no return at %0t", net_rdata, $time);
            end else begin
                check("net_rdata", net_rdata, net_q.pop_front());
            end
        end
    end

    task automatic idle();
        core_v = 0; core_w = 0; core_reserve = 0; core_addr = '0; core_data = '0; core_mask = '0;
        net_v = 0; net_w = 0; net_addr = '0; net_data = '0; net_mask = '0;
        clear_reserve = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic core_req(input logic w, input logic rsv, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
        core_v = 1; core_w = w; core_reserve = rsv; core_addr = a; core_data = d; core_mask = m;
    endtask

    task automatic net_req(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        net_v = 1; net_w = w; net_addr = a; net_data = d; net_mask = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] exp_net;
        exp_net = 12'b0010_0001_0000;   // network wins cycles 4 and 9

        idle();
        mem_rdata = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_mem_v",         32'(mem_v),         32'd0);
        check("rst_core_yumi",     32'(core_yumi),     32'd0);
        check("rst_net_yumi",      32'(net_yumi),      32'd0);
        check("rst_reserved",      32'(reserved),      32'd0);
        check("rst_reserved_addr", 32'(reserved_addr), 32'd0);
        check("rst_break",         32'(break_reserve), 32'd0);

        // Core-only read of 0x10
        next_cycle(); core_req(0, 0, 10'h10, '0, '0);
        @(negedge clk);
        check("core_rd_yumi",     32'(core_yumi), 32'd1);
        check("core_rd_net_yumi", 32'(net_yumi),  32'd0);
        check("core_rd_mem_addr", 32'(mem_addr),  32'h10);
        core_q.push_back(32'hDEAD_BEEF);

        // Network-only read of 0x40
        next_cycle(); net_req(0, 10'h40, '0, '0);
        @(negedge clk);
        check("net_rd_yumi", 32'(net_yumi), 32'd1);
        net_q.push_back(32'h4040_4040);

        // Back-to-back reads, alternating owners
        next_cycle(); core_req(0, 0, 10'h20, '0, '0);
        @(negedge clk); check("b2b_core0", 32'(core_yumi), 32'd1); core_q.push_back(32'h2020_2020);
        next_cycle(); net_req(0, 10'h40, '0, '0);
        @(negedge clk); check("b2b_net",   32'(net_yumi),  32'd1); net_q.push_back(32'h4040_4040);
        next_cycle(); core_req(0, 0, 10'h10, '0, '0);
        @(negedge clk); check("b2b_core1", 32'(core_yumi), 32'd1); core_q.push_back(32'hDEAD_BEEF);

        // Starvation: both valid for 12 cycles
        next_cycle();
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            core_req(0, 0, 10'h10, '0, '0);
            net_req(0, 10'h40, '0, '0);
            @(negedge clk);
            check($sformatf("starve_net_gnt_%0d", i),  32'(net_yumi),  32'(exp_net[i]));
            check($sformatf("starve_core_gnt_%0d", i), 32'(core_yumi), 32'(!exp_net[i]));
            if (net_yumi)  net_q.push_back(32'h4040_4040);
            if (core_yumi) core_q.push_back(32'hDEAD_BEEF);
        end

        // LR to 0x20, then a network write to the reserved word breaks it
        next_cycle(); core_req(0, 1, 10'h20, '0, '0);
        @(negedge clk); core_q.push_back(32'h2020_2020);
        next_cycle(); net_req(1, 10'h20, 32'h0000_00AA, 4'b0001);
        @(negedge clk);
        check("lr_reserved",      32'(reserved),      32'd1);
        check("lr_reserved_addr", 32'(reserved_addr), 32'h20);
        check("wr_net_yumi",      32'(net_yumi),      32'd1);
        check("wr_break_early",   32'(break_reserve), 32'd0);
        next_cycle();
        @(negedge clk);
        check("brk_reserved", 32'(reserved),      32'd0);
        check("brk_pulse",    32'(break_reserve), 32'd1);
        next_cycle();
        @(negedge clk);
        check("brk_pulse_end", 32'(break_reserve), 32'd0);

        // Zero-mask write must not break the reservation
        next_cycle(); core_req(0, 1, 10'h20, '0, '0);
        @(negedge clk); core_q.push_back(32'h2020_20AA);
        next_cycle(); net_req(1, 10'h20, 32'hFFFF_FFFF, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("m0_reserved", 32'(reserved),      32'd1);
        check("m0_no_break", 32'(break_reserve), 32'd0);

        // Plain clear drops the reservation silently
        next_cycle(); clear_reserve = 1;
        next_cycle();
        @(negedge clk);
        check("clr_reserved", 32'(reserved),      32'd0);
        check("clr_no_break", 32'(break_reserve), 32'd0);

        // LR with a same-cycle clear: the set wins
        next_cycle(); core_req(0, 1, 10'h30, '0, '0); clear_reserve = 1;
        @(negedge clk); core_q.push_back(32'h3030_3030);
        next_cycle();
        @(negedge clk);
        check("lrclr_reserved",      32'(reserved),      32'd1);
        check("lrclr_reserved_addr", 32'(reserved_addr), 32'h30);

        // Write followed immediately by a read of the same word
        next_cycle(); net_req(1, 10'h50, 32'h1234_5678, 4'b1111);
        next_cycle(); core_req(0, 0, 10'h50, '0, '0);
        @(negedge clk); core_q.push_back(32'h1234_5678);

        // Reset between a read grant and its return
        next_cycle(); core_req(0, 0, 10'h10, '0, '0);
        @(negedge clk);
        check("rstrd_yumi", 32'(core_yumi), 32'd1);
        #1 reset_n = 1'b0; idle();
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("rstrd_core_v",        32'(core_rdata_v),  32'd0);
        check("rstrd_net_v",         32'(net_rdata_v),   32'd0);
        check("rstrd_reserved",      32'(reserved),      32'd0);
        check("rstrd_reserved_addr", 32'(reserved_addr), 32'd0);
        check("rstrd_break",         32'(break_reserve), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rstrd_core_v_late", 32'(core_rdata_v), 32'd0);

        // After reset the starvation count is zero: core wins a tie
        next_cycle(); core_req(0, 0, 10'h10, '0, '0); net_req(0, 10'h40, '0, '0);
        @(negedge clk);
        check("post_rst_core_gnt", 32'(core_yumi), 32'd1);
        core_q.push_back(32'hDEAD_BEEF);

        repeat (3) next_cycle();
        @(negedge clk);
        check("core_q_drained", 32'(core_q.size()), 32'd0);
        check("net_q_drained",  32'(net_q.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
